ads_int_to_float: RTL

Converts one signed two's-complement ADS1292 sample (24-bit by default) into an IEEE-754 single-precision value. It sits directly upstream of the float filter datapath, including the float multiplier, and feeds it samples.
It uses the same STB/ACK valid-ready handshake on input and output as the float arithmetic units. It is a multi-cycle FSM with one normalisation shift per cycle and round-to-nearest-even.

---
 rtl/ads_int_to_float.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ads_int_to_float.sv
// Purpose: converts a signed two's-complement sample to an IEEE-754 single (RNE).
// Latency: L+4 cycles from input transfer for non-zero input (L = leading zeros of |x|), 1 cycle for zero.
// Backpressure: one sample in flight; o_A_ACK stays low until the result has been taken via i_Z_ACK.
//
// Ports:
//   i_CLK, i_RST      clock, synchronous active-low reset
//   i_A/i_A_STB/o_A_ACK  input sample handshake (IN_WIDTH-bit signed)
//   o_Z/o_Z_STB/i_Z_ACK  output float handshake (32-bit IEEE-754)
module ads_int_to_float #(
    parameter int IN_WIDTH = 24
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic [IN_WIDTH-1:0] i_A,
    input  logic                i_A_STB,
    output logic                o_A_ACK,
    output logic [31:0]         o_Z,
    output logic                o_Z_STB,
    input  logic                i_Z_ACK
);

    // Magnitudes of up to 24 bits always leave the low 8 bits of the
    // normalised magnitude at zero, so the rounding path is only built
    // for wider samples.
    localparam bit ROUND_EN = (IN_WIDTH > 24);

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        NORMALISE,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [31:0]        sample;
    logic [31:0]        m;
    logic signed [9:0]  e;
    logic               s;
    logic [23:0]        mant;

    logic signed [IN_WIDTH-1:0] a_signed;
    logic [31:0]        a_ext;

    logic               guard;
    logic               rnd;
    logic               sticky;
    logic               round_up;
    logic [24:0]        mant_inc;
    logic               unused_bits;

    assign a_signed = i_A;
    assign a_ext    = 32'(a_signed);

    assign guard    = m[7];
    assign rnd      = m[6];
    assign sticky   = |m[5:0];
    // m[8] is the mantissa LSB: on an exact tie round only if it is odd.
    assign round_up = ROUND_EN && guard && (rnd || sticky || m[8]);
    assign mant_inc = {1'b0, m[31:8]} + 25'd1;

    // Exponent never leaves 0..32 and the mantissa MSB is the hidden bit.
    assign unused_bits = ^{e[9:8], mant[23]};

    always_comb begin
        state_nxt = state;
        case (state)
            GET_A:     if (o_A_ACK && i_A_STB) state_nxt = UNPACK;
            UNPACK:    state_nxt = (sample == 32'd0) ? PUT_Z : NORMALISE;
            NORMALISE: if (m[31]) state_nxt = ROUND;
            ROUND:     state_nxt = PACK;
            PACK:      state_nxt = PUT_Z;
            PUT_Z:     if (o_Z_STB && i_Z_ACK) state_nxt = GET_A;
            default:   state_nxt = GET_A;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state   <= GET_A;
            o_A_ACK <= 1'b0;
            o_Z_STB <= 1'b0;
            o_Z     <= 32'h0;
            sample  <= 32'h0;
            m       <= 32'h0;
            e       <= 10'sd0;
            s       <= 1'b0;
            mant    <= 24'h0;
        end else begin
            state <= state_nxt;
            case (state)
                GET_A: begin
                    if (o_A_ACK && i_A_STB) begin
                        sample  <= a_ext;
                        o_A_ACK <= 1'b0;
                    end else begin
                        o_A_ACK <= 1'b1;
                    end
                end
                UNPACK: begin
                    s <= sample[31];
                    // -2^31 negates to itself, which is the correct unsigned magnitude.
                    m <= sample[31] ? (~sample + 32'd1) : sample;
                    e <= 10'sd31;
                    if (sample == 32'd0) begin
                        o_Z     <= 32'h0;
                        o_Z_STB <= 1'b1;
                    end
                end
                NORMALISE: begin
                    if (!m[31]) begin
                        m <= m << 1;
                        e <= e - 10'sd1;
                    end
                end
                ROUND: begin
                    if (round_up) begin
                        if (mant_inc[24]) begin
                            mant <= 24'h800000;
                            e    <= e + 10'sd1;
                        end else begin
                            mant <= mant_inc[23:0];
                        end
                    end else begin
                        mant <= m[31:8];
                    end
                end
                PACK: begin
                    o_Z     <= {s, e[7:0] + 8'd127, mant[22:0]};
                    o_Z_STB <= 1'b1;
                end
                PUT_Z: begin
                    if (o_Z_STB && i_Z_ACK) o_Z_STB <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
